// File: rtl/lc3_pkg.sv
// Shared opcode, state and ALU encodings for the LC-3 control sequencer.
// Also holds the sign-extension and condition-code helpers.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm_sel;
    logic [15:0] imm16;
    logic [15:0] off16;
    logic [2:0]  nzp;
  } dec_t;

  function automatic logic [15:0] sext_imm5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext_off9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    return {v[15], v == 16'h0000, !v[15] && (v != 16'h0000)};
  endfunction

endpackage

// File: rtl/lc3_decode.sv
// Pure field extraction from the instruction register.
// No state; the sequencer decides when the fields matter.
module lc3_decode
  import lc3_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  // Split the instruction word into named fields
  always_comb begin
    dec.opcode  = ir[15:12];
    dec.dr      = ir[11:9];
    dec.sr1     = ir[8:6];
    dec.sr2     = ir[2:0];
    dec.imm_sel = ir[5];
    dec.imm16   = sext_imm5(ir[4:0]);
    dec.off16   = sext_off9(ir[8:0]);
    dec.nzp     = ir[11:9];
  end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer for the LC-3 core.
// Handles ADD, AND, NOT, BR and HALT; anything else pulses illegal_op.
module lc3_ctrl_fsm
  import lc3_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  output logic [2:0]        rf_raddr1,
  output logic [2:0]        rf_raddr2,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [1:0]        alu_op,
  output logic              alu_b_imm,
  output logic [15:0]       imm_out,
  input  logic [15:0]       alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        cc,
  output logic              halted,
  output logic              illegal_op
);

  localparam logic [ADDR_W-1:0] PC_ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [15:0] ir;
  logic        hold;
  dec_t        dec;
  logic        is_alu;
  logic        is_not;
  logic        is_br;
  logic        is_halt;

  lc3_decode u_dec (
    .ir  (ir),
    .dec (dec)
  );

  // Opcode classes used by both DECODE and EXECUTE
  always_comb begin
    is_alu  = (dec.opcode == OP_ADD) ||
              (dec.opcode == OP_AND);
    is_not  = (dec.opcode == OP_NOT);
    is_br   = (dec.opcode == OP_BR);
    is_halt = (dec.opcode == OP_HALT);
  end

  // A started fetch stays requested until memory accepts it
  assign mem_req   = (state == S_FETCH) && (run || hold);
  assign mem_addr  = pc;
  assign rf_raddr1 = dec.sr1;
  assign rf_raddr2 = dec.sr2;
  assign imm_out   = dec.imm16;

  // Sequencer state, architectural registers and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= PC_RESET;
      ir         <= 16'h0000;
      cc         <= 3'b010;
      halted     <= 1'b0;
      hold       <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= 3'd0;
      alu_op     <= ALU_ADD;
      alu_b_imm  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      rf_we      <= 1'b0;
      illegal_op <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_b_imm  <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (mem_req && mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + PC_ONE;
            hold  <= 1'b0;
            state <= S_DECODE;
          end else begin
            hold <= mem_req;
          end
        end
        S_DECODE: begin
          state <= S_EXECUTE;
          unique case (1'b1)
            is_alu: begin
              rf_we     <= 1'b1;
              rf_waddr  <= dec.dr;
              alu_op    <= (dec.opcode == OP_AND) ?
                           ALU_AND : ALU_ADD;
              alu_b_imm <= dec.imm_sel;
            end
            is_not: begin
              rf_we    <= 1'b1;
              rf_waddr <= dec.dr;
              alu_op   <= ALU_NOT;
            end
            is_br, is_halt: ;
            default: illegal_op <= 1'b1;
          endcase
        end
        S_EXECUTE: begin
          state <= S_FETCH;
          unique case (1'b1)
            is_alu, is_not: cc <= nzp_of(alu_result);
            is_br: begin
              if ((dec.nzp & cc) != 3'b000)
                pc <= pc + dec.off16[ADDR_W-1:0];
            end
            is_halt: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed bench for lc3_ctrl_fsm with an instruction-level model.
// Literal checks pin the model at hand-computed points.
module tb_lc3_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [2:0]  rf_raddr1;
  logic [2:0]  rf_raddr2;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [1:0]  alu_op;
  logic        alu_b_imm;
  logic [15:0] imm_out;
  logic [15:0] alu_result;
  logic [15:0] pc;
  logic [2:0]  cc;
  logic        halted;
  logic        illegal_op;

  logic [15:0] prog    [256];
  logic [15:0] alu_tab [256];

  int n_cmp = 0;
  int n_bad = 0;

  // model state: phase 0 fetch, 1 decode, 2 execute, 3 halted
  int          m_ph   = 0;
  logic [15:0] m_pc   = 16'h0;
  logic [15:0] m_ir   = 16'h0;
  logic [15:0] m_ia   = 16'h0;
  logic [2:0]  m_cc   = 3'b010;
  logic        m_halt = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_on   = 1'b0;

  lc3_ctrl_fsm #(.ADDR_W(16), .PC_RESET(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .alu_op     (alu_op),
    .alu_b_imm  (alu_b_imm),
    .imm_out    (imm_out),
    .alu_result (alu_result),
    .pc         (pc),
    .cc         (cc),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  assign mem_rdata  = prog[mem_addr[7:0]];
  assign alu_result = alu_tab[m_ia[7:0]];

  function automatic logic [15:0] sx(input logic [15:0] v,
                                     input int bits);
    logic [15:0] mask;
    logic [15:0] r;
    mask = (16'h1 << bits) - 16'h1;
    r = v & mask;
    if (v[bits-1]) r = r | ~mask;
    return r;
  endfunction

  function automatic bit writes_rf(input logic [3:0] op);
    return op == 4'h1 || op == 4'h5 || op == 4'h9;
  endfunction

  function automatic bit known_op(input logic [3:0] op);
    return writes_rf(op) || op == 4'h0 || op == 4'hF;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // instruction-level reference, advanced on each rising edge
  always @(posedge clk) begin
    logic       req;
    logic [3:0] op;
    if (rst) begin
      m_ph = 0; m_pc = 16'h0; m_ir = 16'h0; m_ia = 16'h0;
      m_cc = 3'b010; m_halt = 1'b0; m_hold = 1'b0; m_on = 1'b1;
    end else if (m_on) begin
      case (m_ph)
        0: begin
          req = run || m_hold;
          if (req && mem_ready) begin
            m_ir = prog[m_pc[7:0]];
            m_ia = m_pc;
            m_pc = m_pc + 16'h1;
            m_hold = 1'b0;
            m_ph = 1;
          end else begin
            m_hold = req;
          end
        end
        1: m_ph = 2;
        2: begin
          op = m_ir[15:12];
          m_ph = 0;
          if (writes_rf(op)) begin
            if (alu_result == 16'h0) m_cc = 3'b010;
            else if (alu_result[15]) m_cc = 3'b100;
            else m_cc = 3'b001;
          end else if (op == 4'h0) begin
            if ((m_ir[11:9] & m_cc) != 3'b000)
              m_pc = m_pc + sx(m_ir, 9);
          end else if (op == 4'hF) begin
            m_ph = 3;
            m_halt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // compare every cycle once the model has been reset
  always @(negedge clk) begin
    logic       ereq;
    logic [3:0] op;
    if (m_on) begin
      op   = m_ir[15:12];
      ereq = (m_ph == 0) && (run || m_hold);
      chk("mem_req", {15'h0, mem_req}, {15'h0, ereq});
      if (ereq) chk("mem_addr", mem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("cc", {13'h0, cc}, {13'h0, m_cc});
      chk("halted", {15'h0, halted}, {15'h0, m_halt});
      chk("rf_we", {15'h0, rf_we},
          {15'h0, (m_ph == 2) && writes_rf(op)});
      chk("illegal_op", {15'h0, illegal_op},
          {15'h0, (m_ph == 2) && !known_op(op)});
      if (m_ph == 1 || m_ph == 2) begin
        chk("rf_raddr1", {13'h0, rf_raddr1}, {13'h0, m_ir[8:6]});
        chk("rf_raddr2", {13'h0, rf_raddr2}, {13'h0, m_ir[2:0]});
        chk("imm_out", imm_out, sx(m_ir, 5));
      end
      if (m_ph == 2 && writes_rf(op)) begin
        chk("rf_waddr", {13'h0, rf_waddr}, {13'h0, m_ir[11:9]});
        chk("alu_op", {14'h0, alu_op},
            (op == 4'h1) ? 16'd0 : (op == 4'h5) ? 16'd1 : 16'd2);
        chk("alu_b_imm", {15'h0, alu_b_imm},
            {15'h0, (op != 4'h9) && m_ir[5]});
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      prog[i] = 16'h0000;
      alu_tab[i] = 16'h0000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1;
    clear_prog();
    prog[0] = 16'h1262; alu_tab[0] = 16'h0005;
    prog[1] = 16'h103F; alu_tab[1] = 16'h8000;
    prog[2] = 16'h5482; alu_tab[2] = 16'h0000;
    prog[3] = 16'hD000;
    prog[4] = 16'hF025;
    do_reset();
    #3;
    chk("t0 mem_req", {15'h0, mem_req}, 16'h1);
    chk("t0 mem_addr", mem_addr, 16'h0000);
    chk("t0 cc", {13'h0, cc}, 16'h2);
    chk("t0 alu_op", {14'h0, alu_op}, 16'h0);
    chk("t0 alu_b_imm", {15'h0, alu_b_imm}, 16'h0);
    cyc(1); #3;
    chk("t1 pc", pc, 16'h0001);
    chk("t1 mem_req", {15'h0, mem_req}, 16'h0);
    chk("t1 raddr1", {13'h0, rf_raddr1}, 16'h1);
    chk("t1 imm", imm_out, 16'h0002);
    cyc(1); #3;
    chk("t2 rf_we", {15'h0, rf_we}, 16'h1);
    chk("t2 waddr", {13'h0, rf_waddr}, 16'h1);
    chk("t2 b_imm", {15'h0, alu_b_imm}, 16'h1);
    cyc(1); #3;
    chk("t3 rf_we", {15'h0, rf_we}, 16'h0);
    chk("t3 mem_req", {15'h0, mem_req}, 16'h1);
    chk("t3 cc", {13'h0, cc}, 16'h1);
    cyc(1); #3;
    chk("t4 imm", imm_out, 16'hFFFF);
    cyc(2); #3;
    chk("t6 cc", {13'h0, cc}, 16'h4);
    cyc(2); #3;
    chk("t8 alu_op", {14'h0, alu_op}, 16'h1);
    chk("t8 b_imm", {15'h0, alu_b_imm}, 16'h0);
    chk("t8 raddr2", {13'h0, rf_raddr2}, 16'h2);
    cyc(1); #3;
    chk("t9 cc", {13'h0, cc}, 16'h2);
    cyc(2); #3;
    chk("t11 illegal", {15'h0, illegal_op}, 16'h1);
    chk("t11 rf_we", {15'h0, rf_we}, 16'h0);
    cyc(1); #3;
    chk("t12 illegal", {15'h0, illegal_op}, 16'h0);
    cyc(3); #3;
    chk("t15 halted", {15'h0, halted}, 16'h1);
    chk("t15 mem_req", {15'h0, mem_req}, 16'h0);
    cyc(10); #3;
    chk("t25 halted", {15'h0, halted}, 16'h1);
    chk("t25 pc", pc, 16'h0005);

    // taken branch back from 0x10
    clear_prog();
    prog[16] = 16'h05FD;
    do_reset();
    #3;
    chk("b1 halted", {15'h0, halted}, 16'h0);
    cyc(48); #3;
    chk("b1 mem_addr", mem_addr, 16'h0010);
    cyc(3); #3;
    chk("b1 pc", pc, 16'h000E);

    // not-taken branch, then halt
    clear_prog();
    prog[16] = 16'h0BFD;
    prog[17] = 16'hF025;
    do_reset();
    cyc(51); #3;
    chk("b2 pc", pc, 16'h0011);
    cyc(3); #3;
    chk("b2 halted", {15'h0, halted}, 16'h1);

    // backward branch through address zero, pc wrap
    clear_prog();
    prog[0] = 16'h0FFE;
    prog[255] = 16'hF025;
    do_reset();
    cyc(3); #3;
    chk("w pc", pc, 16'hFFFF);
    cyc(1); #3;
    chk("w wrap", pc, 16'h0000);
    cyc(2); #3;
    chk("w halted", {15'h0, halted}, 16'h1);

    // run gating, stall and mid-fetch reset
    clear_prog();
    run = 1'b0;
    do_reset();
    #3;
    chk("r0 mem_req", {15'h0, mem_req}, 16'h0);
    cyc(3); #3;
    chk("r3 pc", pc, 16'h0000);
    cyc(1); run = 1'b1; mem_ready = 1'b0; #3;
    chk("s4 mem_req", {15'h0, mem_req}, 16'h1);
    cyc(1); run = 1'b0; #3;
    chk("s5 mem_req", {15'h0, mem_req}, 16'h1);
    cyc(2); #3;
    chk("s7 mem_addr", mem_addr, 16'h0000);
    chk("s7 pc", pc, 16'h0000);
    cyc(1); mem_ready = 1'b1; #3;
    cyc(1); #3;
    chk("s9 pc", pc, 16'h0001);
    run = 1'b1;
    cyc(2); mem_ready = 1'b0; #3;
    chk("s11 mem_req", {15'h0, mem_req}, 16'h1);
    cyc(1); rst = 1'b1; #3;
    cyc(1); rst = 1'b0; #3;
    chk("rr pc", pc, 16'h0000);
    chk("rr halted", {15'h0, halted}, 16'h0);
    mem_ready = 1'b1;
    cyc(4); #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_ctrl_fsm.md
Name: lc3_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the LC-3 core: fetches 16-bit instructions from memory over a req/ready handshake, decodes them, and drives register-file, ALU and PC controls.
- Replaces the "one instruction per clock from a flat vector" execution style with a proper FETCH/DECODE/EXECUTE loop.
- Supported opcodes: ADD, AND, NOT, BR, HALT. Sits between instruction memory and the register file / ALU datapath.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- ADDR_W, 16, memory address / PC width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  when 0, FSM holds in FETCH without issuing mem_req.
- mem_req  out  1  instruction fetch request.
- mem_addr  out  ADDR_W  fetch address (equals pc).
- mem_ready  in  1  memory accepts request and mem_rdata is valid this cycle.
- mem_rdata  in  16  fetched instruction word.
- rf_raddr1  out  3  register-file read port 1 address (SR1).
- rf_raddr2  out  3  register-file read port 2 address (SR2).
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_waddr  out  3  register-file write address (DR).
- alu_op  out  2  00=ADD, 01=AND, 10=NOT, 11=PASS.
- alu_b_imm  out  1  1 = ALU operand B is imm_out, 0 = rf port 2.
- imm_out  out  16  sign-extended imm5 (ir[4:0]).
- alu_result  in  16  ALU output for the current EXECUTE cycle.
- pc  out  ADDR_W  current program counter.
- cc  out  3  condition codes {N,Z,P}.
- halted  out  1  high once HALT has executed.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset (rst=1 at clk edge, any state, including mid-fetch): state=FETCH, pc=PC_RESET, ir=0, cc=3'b010, halted=0. All strobes are 0: mem_req, rf_we, illegal_op. alu_op=00, alu_b_imm=0. An in-flight fetch is abandoned.
- States: FETCH, DECODE, EXECUTE, HALT. Minimum 3 cycles per instruction.
- FETCH:
  - mem_req = run; mem_addr = pc.
  - Once asserted, mem_req and mem_addr stay stable until mem_ready.
  - When mem_req && mem_ready: ir <= mem_rdata, pc <= pc+1 (wraps 16'hFFFF -> 16'h0000), next state DECODE.
  - mem_ready while mem_req=0 is ignored.
  - run dropping while mem_req is already high does not withdraw the request.
- DECODE (1 cycle): rf_raddr1=ir[8:6], rf_raddr2=ir[2:0], imm_out=sext(ir[4:0]). These field outputs hold through EXECUTE.
- EXECUTE (1 cycle), by ir[15:12]:
  - 0001 ADD / 0101 AND:
    - alu_op = 00 or 01; alu_b_imm = ir[5].
    - rf_we=1, rf_waddr=ir[11:9].
    - cc <= {alu_result[15], alu_result==0, !alu_result[15] && alu_result!=0}.
  - 1001 NOT: alu_op=10, alu_b_imm=0, rf_we=1, cc updated as above; ir[5:0] ignored.
  - 0000 BR: if (ir[11:9] & cc) != 0, pc <= pc + sext(ir[8:0]), using the already-incremented pc, modulo 2^16. nzp=000 is never taken. No rf_we; cc unchanged.
  - 1111 HALT: next state HALT; halted <= 1; no rf_we.
  - Any other opcode: illegal_op=1 for this cycle, no other side effects, treated as a NOP.
  - Next state is FETCH unless HALT.
- HALT: absorbing state; mem_req=0, rf_we=0, halted=1; only rst exits.
- rf_we and illegal_op are never high outside EXECUTE.
- Combinational paths: mem_rdata, alu_result and mem_ready have no path to any output in the same cycle, except mem_ready -> state/ir registers.

Decomposition:
- Package lc3_pkg: opcode localparams (OP_ADD, OP_AND, OP_NOT, OP_BR, OP_HALT), state encoding, alu_op encoding, sext helper functions (imm5, PCoffset9).
- Sub-module lc3_decode: combinational ir -> {opcode, dr, sr1, sr2, imm_sel, imm16, off16, nzp}. The FSM instantiates it once.

Test Plan:
- Reset/fetch: rst 1 cycle, run=1, mem_ready=1 always.
  -> mem_req=1, mem_addr=0x0000 in the first cycle; pc=0x0001 after that edge; mem_req high again exactly 3 cycles later.
- ADD imm: mem_rdata=0x1262 (ADD R1,R1,#2), alu_result=0x0005 in EXECUTE.
  -> rf_raddr1=1, alu_b_imm=1, imm_out=0x0002, rf_we=1 with rf_waddr=1 for one cycle, cc=001.
- Negative imm / AND reg: 0x103F (ADD R0,R0,#-1) -> imm_out=0xFFFF. 0x5482 (AND R2,R2,R2) with alu_result=0 -> alu_op=01, alu_b_imm=0, rf_raddr2=2, cc=010.
- Branch: cc=010, pc=0x0010 at fetch, ir=0x05FD (BRz #-3) -> pc=0x000E. Same with ir=0x0BFD (BRnp) -> pc stays 0x0011.
- Fetch stall/run: mem_ready low for 4 cycles -> mem_req and mem_addr stable, pc unchanged. run=0 in FETCH -> mem_req=0, no progress.
- HALT/illegal/reset: 0xF025 -> halted=1 and mem_req=0 forever. 0xD000 -> illegal_op one-cycle pulse, no rf_we. rst asserted mid-FETCH wait -> pc=PC_RESET and halted=0 on the next cycle.
